// File: rtl/ps2_scan_decoder.sv
// PS/2 Set-2 scan code to ASCII decoder with Shift/Caps tracking and an output FIFO.
// Latency: a character is written on the edge that samples scan_valid and is visible at the head in the next cycle.
// Backpressure: valid/ready on the output; when the FIFO is full an unpopped push is dropped and overflow sticks.
module ps2_scan_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [7:0] ascii_data,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic       caps_on,
    output logic       shift_on,
    output logic       overflow
);

    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL_CNT = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]    CNT_ONE  = 1;
    localparam logic [AW-1:0]  PTR_ONE  = 1;

    typedef enum logic [1:0] {
        S_NORMAL,
        S_BREAK,
        S_EXT,
        S_EXT_BREAK
    } state_t;

    state_t state, state_nxt;

    logic lshift, rshift, caps_held;
    logic lshift_nxt, rshift_nxt, caps_held_nxt, caps_nxt;
    logic       push;
    logic [7:0] push_dat;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          full, pop, do_push;

    // Map a make code to its character; letters are stored lowercase and
    // shifted down to uppercase on request. Bit 8 flags a printable code.
    function automatic logic [8:0] translate(input logic [7:0] code, input logic upper);
        logic [7:0] c;
        c = 8'h00;
        case (code)
            8'h1C: c = "a";  8'h32: c = "b";  8'h21: c = "c";  8'h23: c = "d";
            8'h24: c = "e";  8'h2B: c = "f";  8'h34: c = "g";  8'h33: c = "h";
            8'h43: c = "i";  8'h3B: c = "j";  8'h42: c = "k";  8'h4B: c = "l";
            8'h3A: c = "m";  8'h31: c = "n";  8'h44: c = "o";  8'h4D: c = "p";
            8'h15: c = "q";  8'h2D: c = "r";  8'h1B: c = "s";  8'h2C: c = "t";
            8'h3C: c = "u";  8'h2A: c = "v";  8'h1D: c = "w";  8'h22: c = "x";
            8'h35: c = "y";  8'h1A: c = "z";
            8'h45: c = "0";  8'h16: c = "1";  8'h1E: c = "2";  8'h26: c = "3";
            8'h25: c = "4";  8'h2E: c = "5";  8'h36: c = "6";  8'h3D: c = "7";
            8'h3E: c = "8";  8'h46: c = "9";
            8'h29: c = 8'h20;
            8'h5A: c = 8'h0D;
            8'h66: c = 8'h08;
            default: c = 8'h00;
        endcase
        if (upper && (c >= 8'h61)) begin
            c = c - 8'h20;
        end
        return {(c != 8'h00), c};
    endfunction

    // Prefix sequencing, modifier updates and character generation for the sampled byte.
    always_comb begin
        state_nxt     = state;
        lshift_nxt    = lshift;
        rshift_nxt    = rshift;
        caps_held_nxt = caps_held;
        caps_nxt      = caps_on;
        push          = 1'b0;
        push_dat      = 8'h00;
        if (scan_valid) begin
            case (state)
                S_NORMAL: begin
                    if (scan_code == 8'hE0) begin
                        state_nxt = S_EXT;
                    end else if (scan_code == 8'hF0) begin
                        state_nxt = S_BREAK;
                    end else begin
                        case (scan_code)
                            8'h12: lshift_nxt = 1'b1;
                            8'h59: rshift_nxt = 1'b1;
                            8'h58: begin
                                // Only the first make toggles; typematic repeats are ignored until release.
                                if (!caps_held) begin
                                    caps_nxt      = ~caps_on;
                                    caps_held_nxt = 1'b1;
                                end
                            end
                            default: {push, push_dat} = translate(scan_code, shift_on ^ caps_on);
                        endcase
                    end
                end
                S_BREAK: begin
                    case (scan_code)
                        8'h12:   lshift_nxt    = 1'b0;
                        8'h59:   rshift_nxt    = 1'b0;
                        8'h58:   caps_held_nxt = 1'b0;
                        default: ;
                    endcase
                    state_nxt = S_NORMAL;
                end
                S_EXT: begin
                    // Extended makes (arrows, fake shift) produce nothing.
                    state_nxt = (scan_code == 8'hF0) ? S_EXT_BREAK : S_NORMAL;
                end
                default: begin
                    state_nxt = S_NORMAL;
                end
            endcase
        end
    end

    // Decoder state and modifier registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_NORMAL;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            caps_held <= 1'b0;
            caps_on   <= 1'b0;
        end else begin
            state     <= state_nxt;
            lshift    <= lshift_nxt;
            rshift    <= rshift_nxt;
            caps_held <= caps_held_nxt;
            caps_on   <= caps_nxt;
        end
    end

    assign shift_on    = lshift | rshift;
    assign full        = (count == FULL_CNT);
    assign ascii_valid = (count != '0);
    assign pop         = ascii_valid && ascii_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push     = push && (!full || pop);
    // Head is hidden while empty so the idle output is a clean 0x00.
    assign ascii_data  = ascii_valid ? mem[rd_ptr] : 8'h00;

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed and randomized checks of ps2_scan_decoder against a table-driven reference model.
// Latency: outputs compared #1 after every rising edge.
// Backpressure: ascii_ready driven by directed steps and randomly.
module tb_ps2_scan_decoder;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic [7:0] ascii_data;
    logic       ascii_valid;
    logic       ascii_ready = 1'b0;
    logic       caps_on, shift_on, overflow;

    int tests = 0;
    int fails = 0;

    ps2_scan_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .ascii_data  (ascii_data),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .caps_on     (caps_on),
        .shift_on    (shift_on),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    // Reference tables: index i of the letter table is letter 'a'+i, of the digit table '0'+i.
    logic [7:0] let_tab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dig_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool [24]    = '{8'h1C, 8'h32, 8'h21, 8'h12, 8'h59, 8'h58, 8'hE0, 8'hF0,
                                 8'h16, 8'h45, 8'h29, 8'h5A, 8'h66, 8'hAA, 8'h00, 8'h75,
                                 8'h1A, 8'h4D, 8'h3A, 8'hFA, 8'h12, 8'hF0, 8'h58, 8'h2B};

    // Reference model state.
    bit         m_ls, m_rs, m_caps, m_held, m_ovf;
    bit         m_rel, m_ext, m_ext_rel;
    logic [7:0] q [$];
    string      phase = "reset";

    // Returns the character for a make code, or -1 when it produces nothing.
    function automatic int xlate(input logic [7:0] code, input bit up);
        for (int i = 0; i < 26; i++)
            if (code == let_tab[i]) return (up ? 32'h41 : 32'h61) + i;
        for (int i = 0; i < 10; i++)
            if (code == dig_tab[i]) return 32'h30 + i;
        if (code == 8'h29) return 32'h20;
        if (code == 8'h5A) return 32'h0D;
        if (code == 8'h66) return 32'h08;
        return -1;
    endfunction

    task automatic model_clear();
        m_ls = 0; m_rs = 0; m_caps = 0; m_held = 0; m_ovf = 0;
        m_rel = 0; m_ext = 0; m_ext_rel = 0;
        q.delete();
    endtask

    // Applies one clock edge worth of behaviour using pre-edge state.
    task automatic model_edge(input logic [7:0] code, input bit vld, input bit rdy);
        int  ch;
        bit  pop_now;
        bit  was_full;
        ch       = -1;
        pop_now  = (q.size() != 0) && rdy;
        was_full = (q.size() == DEPTH);
        if (vld) begin
            if (m_ext_rel) begin
                m_ext_rel = 0;
            end else if (m_ext) begin
                m_ext = 0;
                if (code == 8'hF0) m_ext_rel = 1;
            end else if (m_rel) begin
                m_rel = 0;
                if (code == 8'h12) m_ls = 0;
                if (code == 8'h59) m_rs = 0;
                if (code == 8'h58) m_held = 0;
            end else if (code == 8'hE0) begin
                m_ext = 1;
            end else if (code == 8'hF0) begin
                m_rel = 1;
            end else if (code == 8'h12) begin
                m_ls = 1;
            end else if (code == 8'h59) begin
                m_rs = 1;
            end else if (code == 8'h58) begin
                if (!m_held) begin
                    m_caps = !m_caps;
                    m_held = 1;
                end
            end else begin
                ch = xlate(code, (m_ls || m_rs) ^ m_caps);
            end
        end
        if (pop_now) void'(q.pop_front());
        if (ch >= 0) begin
            if (was_full && !pop_now) m_ovf = 1;
            else q.push_back(ch[7:0]);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid",    {7'd0, ascii_valid}, {7'd0, q.size() != 0});
        chk("data",     ascii_data,          (q.size() != 0) ? q[0] : 8'h00);
        chk("caps",     {7'd0, caps_on},     {7'd0, m_caps});
        chk("shift",    {7'd0, shift_on},    {7'd0, m_ls || m_rs});
        chk("overflow", {7'd0, overflow},    {7'd0, m_ovf});
    endtask

    task automatic step(input logic [7:0] code, input bit vld, input bit rdy);
        @(negedge clock);
        scan_code   = code;
        scan_valid  = vld;
        ascii_ready = rdy;
        model_edge(code, vld, rdy);
        @(posedge clock);
        #1;
        scan_valid = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset       = 1'b1;
        scan_valid  = 1'b1;   // must be overridden by reset
        scan_code   = 8'h1C;
        ascii_ready = 1'b1;
        @(posedge clock);
        #1;
        reset      = 1'b0;
        scan_valid = 1'b0;
        model_clear();
        check_all();
    endtask

    initial begin
        model_clear();

        // Reset, one letter, consumer ready.
        phase = "basic";
        do_reset();
        step(8'h1C, 1, 1);
        chk("a_valid", {7'd0, ascii_valid}, 8'h01);
        chk("a_data", ascii_data, 8'h61);
        step(8'h00, 0, 1);
        chk("a_popped", {7'd0, ascii_valid}, 8'h00);

        // Shift press and release.
        phase = "shift";
        do_reset();
        step(8'h12, 1, 1);
        chk("shift_held", {7'd0, shift_on}, 8'h01);
        step(8'h1C, 1, 1);
        chk("upper_a", ascii_data, 8'h41);
        step(8'hF0, 1, 1);
        step(8'h12, 1, 1);
        chk("shift_released", {7'd0, shift_on}, 8'h00);
        step(8'h1C, 1, 1);
        chk("lower_a", ascii_data, 8'h61);
        step(8'h00, 0, 1);

        // Caps Lock toggles once per physical press.
        phase = "caps";
        do_reset();
        step(8'h58, 1, 1);
        chk("caps_first", {7'd0, caps_on}, 8'h01);
        step(8'h58, 1, 1);
        step(8'h58, 1, 1);
        chk("caps_repeat", {7'd0, caps_on}, 8'h01);
        step(8'hF0, 1, 1);
        step(8'h58, 1, 1);
        step(8'h58, 1, 1);
        step(8'h58, 1, 1);
        chk("caps_second", {7'd0, caps_on}, 8'h00);
        step(8'h32, 1, 0);
        chk("caps_off_b", ascii_data, 8'h62);

        // Caps gives uppercase, Shift with Caps gives lowercase.
        phase = "xor";
        do_reset();
        step(8'h58, 1, 0);
        step(8'h32, 1, 0);
        chk("caps_b", ascii_data, 8'h42);
        step(8'h00, 0, 1);
        step(8'h12, 1, 0);
        step(8'h32, 1, 0);
        chk("shift_caps_b", ascii_data, 8'h62);

        // Extended sequences are silent, including the fake shift.
        phase = "ext";
        do_reset();
        step(8'hE0, 1, 0);
        step(8'h75, 1, 0);
        step(8'hE0, 1, 0);
        step(8'hF0, 1, 0);
        step(8'h75, 1, 0);
        step(8'hE0, 1, 0);
        step(8'h12, 1, 0);
        chk("ext_silent", {7'd0, ascii_valid}, 8'h00);
        chk("ext_noshift", {7'd0, shift_on}, 8'h00);
        step(8'h16, 1, 0);
        chk("ext_then_1", ascii_data, 8'h31);

        // Fill, overflow, then drain with a simultaneous push.
        phase = "full";
        do_reset();
        step(8'h16, 1, 0);
        step(8'h1E, 1, 0);
        step(8'h26, 1, 0);
        step(8'h25, 1, 0);
        chk("full_no_ovf", {7'd0, overflow}, 8'h00);
        step(8'h2E, 1, 0);
        chk("ovf_set", {7'd0, overflow}, 8'h01);
        chk("ovf_head", ascii_data, 8'h31);
        step(8'h29, 1, 1);
        chk("push_pop_head", ascii_data, 8'h32);
        step(8'h00, 0, 1);
        step(8'h00, 0, 1);
        chk("drain_4", ascii_data, 8'h34);
        step(8'h00, 0, 1);
        chk("drain_space", ascii_data, 8'h20);
        step(8'h00, 0, 1);
        chk("drained", {7'd0, ascii_valid}, 8'h00);
        chk("ovf_sticky", {7'd0, overflow}, 8'h01);

        // A pending release prefix is lost across reset.
        phase = "midreset";
        step(8'hF0, 1, 0);
        do_reset();
        chk("rst_ovf", {7'd0, overflow}, 8'h00);
        step(8'h1C, 1, 0);
        chk("rst_make", ascii_data, 8'h61);

        // Randomized traffic against the model.
        phase = "random";
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(pool[$urandom_range(0, 23)], ($urandom_range(0, 1) == 1),
                     ($urandom_range(0, 2) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
Downstream consumer of the PS/2 keyboard receiver. Takes one-byte Set-2 scan codes and tracks the make/break/extended prefix sequence and the Shift and Caps Lock modifier state. Translates printable key presses into ASCII and buffers them in a small FIFO with a valid/ready handshake toward the LCD write controller.

Parameters:
FIFO_DEPTH, 4, ASCII FIFO entries; power of two, minimum 2.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
scan_code  input  8  scan code byte from the PS/2 receiver
scan_valid  input  1  one-cycle strobe; scan_code valid this cycle
ascii_data  output  8  ASCII character at the FIFO head
ascii_valid  output  1  FIFO not empty
ascii_ready  input  1  consumer accepts head when ascii_valid && ascii_ready
caps_on  output  1  Caps Lock toggle state (drives keyboard/status LED)
shift_on  output  1  either Shift key currently held
overflow  output  1  sticky; a character was dropped because the FIFO was full

Behaviour:
- Reset: FSM to NORMAL; FIFO emptied; ascii_valid=0; ascii_data=0x00; caps_on=0; shift_on=0; overflow=0; internal lshift, rshift and caps_held cleared. Reset overrides a simultaneous scan_valid.
- Every input is sampled only on a clock edge where scan_valid=1. Bytes arriving without scan_valid are ignored.
- FSM states:
  - NORMAL: 0xE0->EXT; 0xF0->BREAK; otherwise handle the byte as a make code and stay in NORMAL.
  - BREAK: the byte is a release code. 0x12 clears lshift; 0x59 clears rshift; 0x58 clears caps_held; all others ignored. Return to NORMAL.
  - EXT: 0xF0->EXT_BREAK; any other byte is an extended make, ignored (no output, including fake-shift E0 12). Return to NORMAL.
  - EXT_BREAK: the byte is ignored. Return to NORMAL.
- Make handling in NORMAL:
  - 0x12 sets lshift; 0x59 sets rshift.
  - 0x58: if caps_held=0, toggle caps_on and set caps_held; if caps_held=1, ignore (typematic repeat must not re-toggle).
  - Printable codes push one ASCII byte. Typematic repeats push again.
  - Unmapped codes, including 0xAA, 0xFA, 0xEE and 0x00, are ignored.
- shift_on = lshift | rshift.
- Letter map: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
  - Output is uppercase (0x41..0x5A) when shift_on XOR caps_on, else lowercase (0x61..0x7A).
- Digit map (unaffected by modifiers): 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
- Other printable codes: 29 space 0x20; 5A enter 0x0D; 66 backspace 0x08.
- Modifier state used for translation is the value before the current edge.
- Latency: push written at the edge sampling scan_valid. ascii_valid and ascii_data reflect it in the next cycle if the FIFO was empty.
- FIFO behaviour:
  - First-word fall-through; ascii_data is always the head entry.
  - Pop on an edge with ascii_valid && ascii_ready.
  - Full: a push with no simultaneous pop is dropped and sets overflow; occupancy is unchanged.
  - Full with simultaneous push and pop: both occur, no overflow.
  - Empty with push and ascii_ready: push only; the pop is gated by ascii_valid=0.
  - Pointers wrap modulo FIFO_DEPTH; a count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- overflow clears only on reset.
- Reset mid-sequence (e.g. after 0xF0 or 0xE0): the prefix is lost and the FSM starts in NORMAL.

Test Plan:
- Reset, then strobe 0x1C with ascii_ready=1 -> next cycle ascii_valid=1, ascii_data=0x61; popped the following edge; FIFO empty.
- 0x12, 0x1C, 0xF0, 0x12, 0x1C -> outputs 0x41 then 0x61; shift_on goes 1 then 0; no output for the modifier bytes.
- 0x58, 0x58, 0x58, 0xF0, 0x58, 0x58, then 0x32 -> caps_on toggles only on the first and fifth make, ending at 0; 0x32 gives 0x62. Separately, 0x58, 0x32 -> 0x42; then 0x12, 0x32 -> 0x62 (shift XOR caps).
- 0xE0, 0x75, 0xE0, 0xF0, 0x75, 0xE0, 0x12, then 0x16 -> no output from the extended sequences, shift_on stays 0, FSM back in NORMAL, 0x16 gives 0x31.
- FIFO_DEPTH=4, ascii_ready=0, push 0x16, 0x1E, 0x26, 0x25, 0x2E -> four entries '1' '2' '3' '4', overflow=1, the fifth character is dropped. Then raise ascii_ready together with a push of 0x29 -> drained order 0x31..0x34 then 0x20.
- 0xF0, then reset, then 0x1C -> reset clears all outputs; 0x1C gives 0x61 (treated as a make, not a release).
